led_scan_ctrl: RTL and testbench
================================

# led_scan_ctrl

Time-multiplexing scan controller for a multi-digit common-segment 7-segment display. It owns the shared segment bus (`o_a`..`o_g`, `o_dp`, same active-high polarity as the single-digit `LED` block) and sequences it across `DIGITS` digit enables. Blanking gaps between digits suppress ghosting. Host writes go to a shadow register file and become visible only at a frame boundary, after a commit, so displayed numbers never tear.

## Interface
Parameters:
- `DIGITS`, 4: number of digits scanned; 2..8.
- `ON_CYC`, 1000: cycles each digit is lit; >= 1.
- `BLANK_CYC`, 16: cycles with all outputs off before each digit; >= 1.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous and active-high.
- `i_en` in 1: display enable. When 0, all segment and digit outputs are forced to 0 and scanning continues.
- `i_we` in 1: shadow write strobe.
- `i_addr` in 3: digit index to write. Writes with `i_addr >= DIGITS` are ignored.
- `i_data` in 4: hex value 0..F.
- `i_blank` in 1: digit blank flag, written with `i_data`.
- `i_dp` in 1: decimal point, written with `i_data`.
- `i_commit` in 1: request a shadow-to-active copy at the next frame boundary.
- `o_a`..`o_g`, `o_dp` out 1 each: segment drives, active-high.
- `o_dig` out `DIGITS`: digit enables, one-hot or zero, active-high.
- `o_frame` out 1: one-cycle pulse on the cycle the active file is updated.
- `o_pending` out 1: a commit is requested but not yet applied.

## Operation
- Register files: shadow and active, each holding `{blank, dp, hex[3:0]}` per digit. Reset value of every entry is blank=1, dp=0, hex=0.
- Scan FSM states are BLANK and ON. A cycle counter and a digit index `k` are kept.
  - BLANK: all outputs 0. After `BLANK_CYC` cycles, go to ON.
  - ON: `o_dig[k]`=1. Segments show `decode(active[k].hex)` and `o_dp`=`active[k].dp`. If `active[k].blank` is set, segments and dp are 0 while `o_dig[k]` stays 1. After `ON_CYC` cycles, go to BLANK and set `k` to `(k+1) mod DIGITS`.
- Frame boundary: the first BLANK cycle with `k`=0.
- Commit:
  - `i_commit` sets the pending flag.
  - At the frame boundary, if the pending flag was set before that edge, copy all shadow entries to active, clear pending, and pulse `o_frame`.
  - A commit arriving on the boundary cycle itself stays pending and is applied at the next frame.
- Writes: `i_we` updates `shadow[i_addr]` on the clock edge.
  - A write in the same cycle as the copy edge is not included in that copy. It is applied by the next commit.
  - A write and a commit in the same cycle: the write is included in that commit.
- Decode is standard hex, segments a..g active-high:
  - 0=1111110, 1=0110000, 8=1111111.
  - A..F use upper-case A, b, C, d, E, F.
- `i_en`=0 masks outputs only. The FSM, commit and `o_frame` are unaffected.

## Timing
- All outputs are registered. Reset values: every output is 0, state is BLANK, `k`=0, counter is 0, pending is 0.
- After `rst` is released, the first `BLANK_CYC` cycles show zeros. The cycle after that has `o_dig`=0001. No `o_frame` fires without a commit.
- Per-digit period is `BLANK_CYC+ON_CYC`. Frame period is `DIGITS*(BLANK_CYC+ON_CYC)`.
- Worst-case latency from commit to `o_frame` is one frame plus 1 cycle.
- `o_dig` never has two bits set, and there is never a cycle where the enable moves directly from digit `k` to `k+1`.
- `rst` asserted mid-scan: on the next edge, return to reset values, reinitialise both register files, and drop any pending commit.
- Counter width is `$clog2(max(ON_CYC,BLANK_CYC))`. The counter compares against `ON_CYC-1` / `BLANK_CYC-1` and never wraps.

## Structure
- Shared package `led_pkg`:
  - 7-bit segment constants per hex value.
  - The digit entry struct `{blank, dp, hex}`.
  - The FSM state enum.
- Sub-module `led_seg_decode`: combinational hex to 7 bits. The controller registers its output.
- All other logic lives in `led_scan_ctrl`: FSM, counters, register files, commit logic.

## Test plan
- Reset with `DIGITS`=4, `ON_CYC`=4, `BLANK_CYC`=2:
  - All outputs stay 0 for 2 cycles.
  - `o_dig` then steps 0001, 0010, 0100, 1000, each lit 4 cycles with 2 zero cycles between.
  - Segments stay 0 because all entries are blank.
- Write 1,2,3,8 to digits 0..3 with blank=0, then commit:
  - `o_pending`=1 until the boundary, then `o_frame` pulses once.
  - Next frame shows 0110000, 1101101, 1111001, 1111111.
- Write digit 0 =5 without a commit: the display is unchanged for 3 frames. Commit: 1011011 appears from the next frame.
- Write on the copy-edge cycle, and commit on the boundary cycle: neither is applied in that frame. Both are applied one frame later, with exactly one `o_frame` per applied commit.
- Drop `i_en` for 10 cycles mid-ON: outputs are 0 and the scan position after re-enable matches the unmasked reference count.
- Assert `rst` for 1 cycle mid-ON of digit 2 with a commit pending: all outputs are 0 next cycle, pending is cleared, and the sequence restarts as in the first scenario.

Source files
------------

// File: rtl/led_pkg.sv
// Shared definitions for the LED scan controller slice.
//   digit_t       : one display entry {blank, dp, hex}
//   scan_state_e  : scan FSM states (BLANK gap, ON lit)
//   SEG_*         : active-high segment patterns, bit 6 = a ... bit 0 = g
//   hex_to_seg()  : hex digit to segment pattern lookup
package led_pkg;

  typedef struct packed {
    logic       blank;
    logic       dp;
    logic [3:0] hex;
  } digit_t;

  localparam digit_t DIGIT_RESET = '{blank: 1'b1, dp: 1'b0, hex: 4'h0};

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } scan_state_e;

  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;
  localparam logic [6:0] SEG_A = 7'b1110111;
  localparam logic [6:0] SEG_B = 7'b0011111;
  localparam logic [6:0] SEG_C = 7'b1001110;
  localparam logic [6:0] SEG_D = 7'b0111101;
  localparam logic [6:0] SEG_E = 7'b1001111;
  localparam logic [6:0] SEG_F = 7'b1000111;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    case (hex)
      4'h0: return SEG_0;
      4'h1: return SEG_1;
      4'h2: return SEG_2;
      4'h3: return SEG_3;
      4'h4: return SEG_4;
      4'h5: return SEG_5;
      4'h6: return SEG_6;
      4'h7: return SEG_7;
      4'h8: return SEG_8;
      4'h9: return SEG_9;
      4'hA: return SEG_A;
      4'hB: return SEG_B;
      4'hC: return SEG_C;
      4'hD: return SEG_D;
      4'hE: return SEG_E;
      default: return SEG_F;
    endcase
  endfunction

endpackage

// File: rtl/led_seg_decode.sv
// Combinational hex to 7-segment decoder (active-high, bit 6 = a ... bit 0 = g).
//   hex : 4-bit value 0..F
//   seg : segment pattern; the caller registers it
module led_seg_decode
  import led_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = hex_to_seg(hex);
  end

endmodule

// File: rtl/led_scan_ctrl.sv
// Time-multiplexed scan controller for a multi-digit common-segment display.
// Each digit gets a BLANK_CYC all-off gap followed by ON_CYC lit cycles.
// Host writes land in a shadow file; a commit copies shadow to active at the
// next frame boundary (first BLANK cycle of digit 0) so numbers never tear.
//   clk, rst          : clock, synchronous active-high reset
//   i_en              : output enable (masks outputs only)
//   i_we/i_addr/i_data/i_blank/i_dp : shadow write port
//   i_commit          : request shadow-to-active copy at next frame boundary
//   o_a..o_g, o_dp    : registered segment drives, active-high
//   o_dig             : registered digit enables, one-hot or zero
//   o_frame           : one-cycle pulse on the cycle the active file updates
//   o_pending         : commit requested but not yet applied
module led_scan_ctrl
  import led_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int ON_CYC    = 1000,
  parameter int BLANK_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [2:0]        i_addr,
  input  logic [3:0]        i_data,
  input  logic              i_blank,
  input  logic              i_dp,
  input  logic              i_commit,
  output logic              o_a,
  output logic              o_b,
  output logic              o_c,
  output logic              o_d,
  output logic              o_e,
  output logic              o_f,
  output logic              o_g,
  output logic              o_dp,
  output logic [DIGITS-1:0] o_dig,
  output logic              o_frame,
  output logic              o_pending
);

  localparam int CNT_MAX = (ON_CYC > BLANK_CYC) ? ON_CYC : BLANK_CYC;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int KW      = $clog2(DIGITS);

  localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYC - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [KW-1:0] K_LAST     = KW'(DIGITS - 1);

  scan_state_e st, st_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [KW-1:0] k, k_nx;

  digit_t shadow [DIGITS];
  digit_t active [DIGITS];
  logic   pending;
  logic   copy;
  logic   addr_ok;

  digit_t            cur;
  logic [6:0]        seg_dec;
  logic [6:0]        seg_nx, seg_q;
  logic              dp_nx;
  logic [DIGITS-1:0] dig_nx;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      st  <= ST_BLANK;
      cnt <= '0;
      k   <= '0;
    end else begin
      st  <= st_nx;
      cnt <= cnt_nx;
      k   <= k_nx;
    end
  end

  // Next-state logic. The counter restarts on every state change, so it
  // never needs to wrap.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    st_nx  = st;
    cnt_nx = cnt + 1'b1;
    k_nx   = k;
    case (st)
      ST_BLANK: begin
        if (cnt == BLANK_LAST) begin
          st_nx  = ST_ON;
          cnt_nx = '0;
        end
      end
      ST_ON: begin
        if (cnt == ON_LAST) begin
          st_nx  = ST_BLANK;
          cnt_nx = '0;
          k_nx   = (k == K_LAST) ? '0 : k + 1'b1;
        end
      end
      default: begin
        st_nx  = ST_BLANK;
        cnt_nx = '0;
      end
    endcase
  end

  // The copy edge is the one leaving the last digit's ON phase; the cycle
  // after it is the frame boundary. Only a commit already pending counts.
  assign copy    = (st == ST_ON) && (cnt == ON_LAST) && (k == K_LAST) && pending;
  assign addr_ok = (32'(i_addr) < 32'(DIGITS));

  // Output logic: computed from the next state so the registered outputs line
  // up with the state they describe. Active never changes on an edge into ON,
  // so reading it here is safe.
  assign cur = active[k_nx];

  led_seg_decode u_dec (
    .hex (cur.hex),
    .seg (seg_dec)
  );

  always_comb begin
    seg_nx = '0;
    dp_nx  = 1'b0;
    dig_nx = '0;
    if (i_en && (st_nx == ST_ON)) begin
      dig_nx = DIGITS'(1) << k_nx;
      if (!cur.blank) begin
        seg_nx = seg_dec;
        dp_nx  = cur.dp;
      end
    end
  end

  // Register files, commit tracking and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the register files are reset explicitly because reset must
      // reinitialise every displayed entry, not just the control state.
      for (int i = 0; i < DIGITS; i++) begin
        shadow[i] <= DIGIT_RESET;
        active[i] <= DIGIT_RESET;
      end
      pending <= 1'b0;
      seg_q   <= '0;
      o_dp    <= 1'b0;
      o_dig   <= '0;
      o_frame <= 1'b0;
    end else begin
      // Copy uses pre-edge shadow, so a write on the copy edge waits.
      if (copy) active <= shadow;
      if (i_we && addr_ok)
        shadow[i_addr[KW-1:0]] <= '{blank: i_blank, dp: i_dp, hex: i_data};
      pending <= i_commit | (pending & ~copy);
      seg_q   <= seg_nx;
      o_dp    <= dp_nx;
      o_dig   <= dig_nx;
      o_frame <= copy;
    end
  end

  assign {o_a, o_b, o_c, o_d, o_e, o_f, o_g} = seg_q;
  assign o_pending = pending;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Self-checking bench for led_scan_ctrl with DIGITS=4, ON_CYC=4, BLANK_CYC=2.
// The reference model tracks elapsed cycles since reset and derives the scan
// position arithmetically (frame position, slot, offset in slot).
module tb_led_scan_ctrl;

  localparam int DIGITS    = 4;
  localparam int ON_CYC    = 4;
  localparam int BLANK_CYC = 2;
  localparam int SLOT      = ON_CYC + BLANK_CYC;
  localparam int FRAME     = DIGITS * SLOT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_en = 1'b1;
  logic i_we = 1'b0;
  logic [2:0] i_addr = '0;
  logic [3:0] i_data = '0;
  logic i_blank = 1'b0;
  logic i_dp = 1'b0;
  logic i_commit = 1'b0;
  logic o_a, o_b, o_c, o_d, o_e, o_f, o_g, o_dp;
  logic [DIGITS-1:0] o_dig;
  logic o_frame, o_pending;

  always #5 clk = ~clk;

  led_scan_ctrl #(.DIGITS(DIGITS), .ON_CYC(ON_CYC), .BLANK_CYC(BLANK_CYC)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_en      (i_en),
    .i_we      (i_we),
    .i_addr    (i_addr),
    .i_data    (i_data),
    .i_blank   (i_blank),
    .i_dp      (i_dp),
    .i_commit  (i_commit),
    .o_a       (o_a),
    .o_b       (o_b),
    .o_c       (o_c),
    .o_d       (o_d),
    .o_e       (o_e),
    .o_f       (o_f),
    .o_g       (o_g),
    .o_dp      (o_dp),
    .o_dig     (o_dig),
    .o_frame   (o_frame),
    .o_pending (o_pending)
  );

  // Standard hex segment patterns, a..g, written out independently.
  logic [6:0] seg_tab [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  int checks = 0;
  int errors = 0;
  int frames_seen = 0;

  // Reference model: entries are {blank, dp, hex}.
  int       t = 0;
  bit       pend = 1'b0;
  bit       en_q = 1'b0;
  bit       frame_exp = 1'b0;
  bit [5:0] sh  [DIGITS];
  bit [5:0] act [DIGITS];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  function automatic logic [6:0] seg_out();
    return {o_a, o_b, o_c, o_d, o_e, o_f, o_g};
  endfunction

  // Advance one clock, update the model with the inputs sampled at that edge,
  // then compare every output against the model.
  task automatic tick();
    int pos, slot;
    bit lit;
    logic [DIGITS-1:0] e_dig;
    logic [6:0] e_seg;
    logic e_dp;
    @(posedge clk);
    frame_exp = 1'b0;
    if (rst) begin
      t = 0;
      pend = 1'b0;
      en_q = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
        sh[i]  = 6'b100000;
        act[i] = 6'b100000;
      end
    end else begin
      t = t + 1;
      if ((t % FRAME == 0) && pend) begin
        for (int i = 0; i < DIGITS; i++) act[i] = sh[i];
        pend = 1'b0;
        frame_exp = 1'b1;
      end
      if (i_we && (int'(i_addr) < DIGITS)) sh[int'(i_addr)] = {i_blank, i_dp, i_data};
      if (i_commit) pend = 1'b1;
      en_q = i_en;
    end
    #1;
    pos  = t % FRAME;
    slot = pos / SLOT;
    lit  = ((pos % SLOT) >= BLANK_CYC) && en_q;
    e_dig = lit ? DIGITS'(1) << slot : '0;
    e_seg = (lit && !act[slot][5]) ? seg_tab[act[slot][3:0]] : 7'b0;
    e_dp  = lit && !act[slot][5] && act[slot][4];
    check("dig", 32'(o_dig), 32'(e_dig));
    check("seg", 32'(seg_out()), 32'(e_seg));
    check("dp", 32'(o_dp), 32'(e_dp));
    check("frame", 32'(o_frame), 32'(frame_exp));
    check("pending", 32'(o_pending), 32'(pend));
    if (o_frame) frames_seen++;
  endtask

  task automatic wr(input int a, input int d, input bit b, input bit p, input bit c);
    i_we = 1'b1;
    i_addr = a[2:0];
    i_data = d[3:0];
    i_blank = b;
    i_dp = p;
    i_commit = c;
    tick();
    i_we = 1'b0;
    i_commit = 1'b0;
  endtask

  // Tick until the model frame position equals p (at least one tick).
  task automatic wait_pos(input int p);
    for (int n = 0; n < FRAME + 1; n++) begin
      tick();
      if (t % FRAME == p) return;
    end
    errors++;
    $error("FAIL wait_pos timeout observed=%0d expected=%0d", t % FRAME, p);
  endtask

  initial begin
    // Reset and blank-entry scan.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("reset_gap", 32'(o_dig), 32'h0);
    tick();
    check("first_digit", 32'(o_dig), 32'h1);
    repeat (FRAME) tick();

    // Write 1,2,3,8 and commit together with the last write.
    wr(0, 1, 0, 0, 0);
    wr(1, 2, 0, 0, 0);
    wr(2, 3, 0, 0, 0);
    frames_seen = 0;
    wr(3, 8, 0, 0, 1);
    check("pend_after_commit", 32'(o_pending), 32'h1);
    for (int n = 0; n < 2 * FRAME && o_pending; n++) tick();
    check("one_frame_pulse", 32'(frames_seen), 32'd1);
    wait_pos(BLANK_CYC);
    check("d0_is_1", 32'(seg_out()), 32'(7'b0110000));
    wait_pos(SLOT + BLANK_CYC);
    check("d1_is_2", 32'(seg_out()), 32'(7'b1101101));
    wait_pos(2 * SLOT + BLANK_CYC);
    check("d2_is_3", 32'(seg_out()), 32'(7'b1111001));
    wait_pos(3 * SLOT + BLANK_CYC);
    check("d3_is_8", 32'(seg_out()), 32'(7'b1111111));

    // Uncommitted write stays invisible for three frames.
    wr(0, 5, 0, 0, 0);
    frames_seen = 0;
    repeat (3 * FRAME) tick();
    check("no_frame_wo_commit", 32'(frames_seen), 32'd0);
    wait_pos(BLANK_CYC);
    check("d0_still_1", 32'(seg_out()), 32'(7'b0110000));
    i_commit = 1'b1;
    tick();
    i_commit = 1'b0;
    wait_pos(BLANK_CYC);
    check("d0_is_5", 32'(seg_out()), 32'(7'b1011011));

    // Write on the copy edge, commit on the boundary cycle.
    wait_pos(FRAME - 1);
    frames_seen = 0;
    wr(1, 9, 0, 0, 0);
    check("no_frame_copy_edge", 32'(o_frame), 32'h0);
    i_commit = 1'b1;
    tick();
    i_commit = 1'b0;
    wait_pos(SLOT + BLANK_CYC);
    check("d1_not_yet", 32'(seg_out()), 32'(7'b1101101));
    wait_pos(SLOT + BLANK_CYC);
    check("d1_is_9", 32'(seg_out()), 32'(7'b1111011));
    check("late_commit_frames", 32'(frames_seen), 32'd1);

    // Enable masked for 10 cycles mid-ON.
    wait_pos(2 * SLOT + BLANK_CYC + 1);
    i_en = 1'b0;
    repeat (10) tick();
    check("masked_dig", 32'(o_dig), 32'h0);
    i_en = 1'b1;
    repeat (FRAME) tick();

    // Reset mid-ON of digit 2 with a commit pending.
    wait_pos(1);
    wr(2, 7, 0, 1, 1);
    wait_pos(2 * SLOT + BLANK_CYC + 1);
    check("pend_before_rst", 32'(o_pending), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_dig", 32'(o_dig), 32'h0);
    check("rst_pending", 32'(o_pending), 32'h0);
    tick();
    tick();
    check("restart_digit0", 32'(o_dig), 32'h1);
    check("restart_blank", 32'(seg_out()), 32'h0);
    repeat (FRAME) tick();

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      i_we     = ($urandom_range(0, 2) == 0);
      i_addr   = 3'($urandom_range(0, 7));
      i_data   = 4'($urandom_range(0, 15));
      i_blank  = ($urandom_range(0, 3) == 0);
      i_dp     = 1'($urandom_range(0, 1));
      i_commit = ($urandom_range(0, 15) == 0);
      i_en     = ($urandom_range(0, 7) != 0);
      rst      = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    i_we = 1'b0;
    i_commit = 1'b0;
    i_en = 1'b1;
    repeat (2 * FRAME) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
